// File: rtl/pic_frame_loader.sv
// pic_frame_loader: frames a byte stream into a double-buffered picture memory.
// Parameters: ADDR_W, DATA_W (8 only), HEAD (bank 0 base), FRAME_LEN, SYNC_BYTE.
// Ports: clk; rst_N (sync, active-low); in_data/in_valid/in_ready stream;
//   frame_sync (viewer frame boundary); mem_we/mem_wa/mem_wd write port;
//   bank_rd (displayed bank); busy, frame_done, frame_err status.
// Build option: define LOADER_CHKSUM_EN to add the trailing mod-256 checksum
//   byte and the frame_err path; undefined, frames complete on the last pixel.
module pic_frame_loader #(
    parameter int unsigned             ADDR_W    = 16,
    parameter int unsigned             DATA_W    = 8,
    parameter int unsigned             HEAD      = 0,
    parameter int unsigned             FRAME_LEN = 768,
    parameter logic [DATA_W-1:0]       SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_N,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_sync,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd,
    output logic              bank_rd,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(HEAD);
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(HEAD + FRAME_LEN);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
`ifdef LOADER_CHKSUM_EN
        CHK  = 2'd2,
`endif
        WAIT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_q, pend_d;
    logic               bank_q, bank_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  wa_q, wa_d;
    logic [DATA_W-1:0]  wd_q, wd_d;
    logic               done_q, done_d;
    logic               xfer;
    logic               complete;
`ifdef LOADER_CHKSUM_EN
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic               err_q, err_d;
`endif

    // in_ready is held low while reset is asserted so no byte is taken then.
    assign in_ready   = rst_N && (state_q != WAIT);
    assign xfer       = in_valid && in_ready;
    assign mem_we     = we_q;
    assign mem_wa     = wa_q;
    assign mem_wd     = wd_q;
    assign bank_rd    = bank_q;
    assign frame_done = done_q;
`ifdef LOADER_CHKSUM_EN
    assign busy       = (state_q == LOAD) || (state_q == CHK);
    assign frame_err  = err_q;
`else
    assign busy       = (state_q == LOAD);
    assign frame_err  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        bank_d   = bank_q;
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        done_d   = 1'b0;
        complete = 1'b0;
`ifdef LOADER_CHKSUM_EN
        sum_d    = sum_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            HUNT: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d = LOAD;
                    idx_d   = '0;
`ifdef LOADER_CHKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    we_d  = 1'b1;
                    // write bank is the one not being displayed
                    wa_d  = (bank_q ? BASE0 : BASE1) + ADDR_W'(idx_q);
                    wd_d  = in_data;
                    idx_d = idx_q + 1'b1;
`ifdef LOADER_CHKSUM_EN
                    sum_d = sum_q + in_data;
                    if (idx_q == LAST) state_d = CHK;
`else
                    if (idx_q == LAST) complete = 1'b1;
`endif
                end
            end
`ifdef LOADER_CHKSUM_EN
            CHK: begin
                if (xfer) begin
                    if (in_data == sum_q) begin
                        complete = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
`endif
            WAIT: begin
            end
            default: state_d = HUNT;
        endcase

        if (complete) begin
            done_d  = 1'b1;
            pend_d  = 1'b1;
            state_d = WAIT;
        end

        // A frame finishing in the sync cycle is shown at once.
        if (frame_sync && (pend_q || complete)) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
            if ((state_q == WAIT) || complete) state_d = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            state_q <= HUNT;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            bank_q  <= 1'b0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
        end
    end

`ifdef LOADER_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_N) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
`endif

endmodule
